// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle controller: opcode values,
// ALU-op and PC-source encodings, FSM states and the one-hot opcode class.
package multicycle_control_pkg;

    // Opcode field values (instruction bits [6:0])
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation selector
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_I   = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_BR  = 2'b11;

    // PC source selector
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_RS1   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // One-hot opcode class; all-zero means unsupported opcode
    typedef struct packed {
        logic r_type;
        logic i_type;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller side is the
// master of the memory request; the datapath/memory side is the slave.
interface multicycle_control_if;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       br_cond;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] rw_type;
    logic       illegal;
    logic       bus_err;
    logic       halted;

    modport master (
        input  opcode, func3, br_cond, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, alu_src, alu_op, rw_type, illegal, bus_err, halted
    );

    modport slave (
        output opcode, func3, br_cond, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, alu_src, alu_op, rw_type, illegal, bus_err, halted
    );

endinterface

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier: one-hot class plus a legal flag.
module opcode_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_t  cls_o,
    output logic       legal_o
);

    // Exactly one class bit is set for a supported opcode, none otherwise
    always_comb begin
        cls_o        = '0;
        cls_o.r_type = (opcode_i == OP_R_TYPE);
        cls_o.i_type = (opcode_i == OP_I_TYPE);
        cls_o.load   = (opcode_i == OP_LOAD);
        cls_o.store  = (opcode_i == OP_STORE);
        cls_o.branch = (opcode_i == OP_B_TYPE);
        cls_o.jal    = (opcode_i == OP_JAL);
        cls_o.jalr   = (opcode_i == OP_JALR);
        cls_o.lui    = (opcode_i == OP_LUI);
        cls_o.auipc  = (opcode_i == OP_AUIPC);
        legal_o      = |cls_o;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait timeout, sticky illegal/bus-error flags and a halting TRAP state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    if (MEM_TIMEOUT < 0 || MEM_TIMEOUT >= (1 << TO_W)) begin : g_to_range
        $error("MEM_TIMEOUT must fit in TO_W bits");
    end

    // Timeout fires when the last allowed wait cycle also sees no ready
    localparam bit            TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    op_class_t cls;
    logic      legal;

    logic       mem_req_c, mem_we_c, ir_write_c, pc_write_c;
    logic       reg_write_c, mem_to_reg_c, alu_src_c;
    logic [1:0] pc_src_c, alu_op_c;
    logic       in_access, to_hit;

    opcode_decode u_dec (
        .opcode_i (bus.opcode),
        .cls_o    (cls),
        .legal_o  (legal)
    );

    assign in_access = (state_q == S_FETCH) || (state_q == S_MEM);
    assign to_hit    = TO_EN && (cnt_q == TO_LAST) && !bus.mem_ready;

    // State, wait counter and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state and control strobes from current state and inputs
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = PC_PLUS4;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (to_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (1'b1)
                    cls.r_type:                     alu_op_c = ALU_R;
                    cls.i_type: begin
                        alu_op_c  = ALU_I;
                        alu_src_c = 1'b1;
                    end
                    cls.load, cls.store, cls.jalr:  alu_src_c = 1'b1;
                    cls.branch:                     alu_op_c = ALU_BR;
                    cls.jal, cls.lui, cls.auipc:    alu_op_c = ALU_ADD;
                    default: ;
                endcase
                if (cls.branch) begin
                    // Branch resolves here; no writeback
                    pc_write_c = 1'b1;
                    pc_src_c   = bus.br_cond ? PC_IMM : PC_PLUS4;
                    state_d    = S_FETCH;
                end else if (cls.load || cls.store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = cls.store;
                if (bus.mem_ready) begin
                    if (cls.store) begin
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (to_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = cls.load;
                pc_write_c   = 1'b1;
                pc_src_c     = cls.jal ? PC_IMM : (cls.jalr ? PC_RS1 : PC_PLUS4);
                state_d      = S_FETCH;
            end
            default: ;  // S_TRAP: everything quiet until reset
        endcase
    end

    // Wait counter: restart on any state change, count idle access cycles
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_access && !bus.mem_ready) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // Outputs are forced quiet while reset is held
    assign bus.mem_req    = rst_n & mem_req_c;
    assign bus.mem_we     = rst_n & mem_we_c;
    assign bus.ir_write   = rst_n & ir_write_c;
    assign bus.pc_write   = rst_n & pc_write_c;
    assign bus.pc_src     = rst_n ? pc_src_c : 2'b00;
    assign bus.reg_write  = rst_n & reg_write_c;
    assign bus.mem_to_reg = rst_n & mem_to_reg_c;
    assign bus.alu_src    = rst_n & alu_src_c;
    assign bus.alu_op     = rst_n ? alu_op_c : 2'b00;
    assign bus.rw_type    = bus.func3;
    assign bus.illegal    = rst_n & illegal_q;
    assign bus.bus_err    = rst_n & bus_err_q;
    assign bus.halted     = rst_n & (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-instruction model expands
// each instruction into its expected cycle-by-cycle output trace.
module tb_multicycle_control;

    localparam int TMO = 4;

    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4,
                   C_B = 5, C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUIPC = 9;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [2:0] rw_type;
        logic       illegal;
        logic       bus_err;
        logic       halted;
    } obs_t;

    typedef struct {
        logic rdy;
        obs_t exp;
    } step_t;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    step_t      plan[$];
    bit         ill_s, berr_s;
    logic [2:0] cur_f3;
    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                            7'b0010111};

    multicycle_control_if bus();

    multicycle_control #(.MEM_TIMEOUT(TMO), .TO_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input obs_t act, input obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic obs_t act_obs();
        obs_t a;
        a.mem_req    = bus.mem_req;
        a.mem_we     = bus.mem_we;
        a.ir_write   = bus.ir_write;
        a.pc_write   = bus.pc_write;
        a.pc_src     = bus.pc_src;
        a.reg_write  = bus.reg_write;
        a.mem_to_reg = bus.mem_to_reg;
        a.alu_src    = bus.alu_src;
        a.alu_op     = bus.alu_op;
        a.rw_type    = bus.rw_type;
        a.illegal    = bus.illegal;
        a.bus_err    = bus.bus_err;
        a.halted     = bus.halted;
        return a;
    endfunction

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_B;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic obs_t base(input logic [2:0] f3);
        obs_t o = '0;
        o.rw_type = f3;
        o.illegal = ill_s;
        o.bus_err = berr_s;
        return o;
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic rdy, input obs_t e);
        step_t s;
        s.rdy = rdy;
        s.exp = e;
        plan.push_back(s);
    endfunction

    function automatic void push_halt(input logic [2:0] f3);
        obs_t o = base(f3);
        o.halted = 1'b1;
        for (int k = 0; k < 3; k++) push(rnd1(), o);
    endfunction

    // Wait cycles of a memory access; returns 0 if the access times out
    function automatic bit wait_phase(input int dly, input obs_t e);
        int waits = (dly >= TMO) ? TMO : dly;
        for (int k = 0; k < waits; k++) push(1'b0, e);
        if (dly >= TMO) begin
            berr_s = 1'b1;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expand one instruction into its expected trace; returns 1 if it traps
    function automatic bit build(input logic [6:0] op, input logic [2:0] f3,
                                 input logic bc, input int dF, input int dM);
        int   c = cls_of(op);
        obs_t o = base(f3);
        o.mem_req = 1'b1;
        if (!wait_phase(dF, o)) begin
            push_halt(f3);
            return 1'b1;
        end
        o.ir_write = 1'b1;
        push(1'b1, o);
        push(rnd1(), base(f3));                      // decode
        if (c == C_ILL) begin
            ill_s = 1'b1;
            push_halt(f3);
            return 1'b1;
        end
        o = base(f3);                                // execute
        case (c)
            C_R:                begin o.alu_op = 2'b10; end
            C_I:                begin o.alu_op = 2'b01; o.alu_src = 1'b1; end
            C_LD, C_ST, C_JALR: begin o.alu_src = 1'b1; end
            C_B:                begin o.alu_op = 2'b11; end
            default: ;
        endcase
        if (c == C_B) begin
            o.pc_write = 1'b1;
            o.pc_src   = bc ? 2'b01 : 2'b00;
            push(rnd1(), o);
            return 1'b0;
        end
        push(rnd1(), o);
        if (c == C_LD || c == C_ST) begin
            o = base(f3);
            o.mem_req = 1'b1;
            o.mem_we  = (c == C_ST);
            if (!wait_phase(dM, o)) begin
                push_halt(f3);
                return 1'b1;
            end
            o.pc_write = (c == C_ST);
            push(1'b1, o);
            if (c == C_ST) return 1'b0;
        end
        o = base(f3);                                // writeback
        o.reg_write  = 1'b1;
        o.mem_to_reg = (c == C_LD);
        o.pc_write   = 1'b1;
        o.pc_src     = (c == C_JAL) ? 2'b01 : ((c == C_JALR) ? 2'b10 : 2'b00);
        push(rnd1(), o);
        return 1'b0;
    endfunction

    // Called at posedge+1: drive ready, check mid-cycle, advance one cycle
    task automatic run_cycle(input string tag, input logic rdy, input obs_t exp);
        bus.mem_ready = rdy;
        @(negedge clk);
        chk(tag, act_obs(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_plan(input string tag, input int limit);
        for (int i = 0; i < plan.size() && i < limit; i++)
            run_cycle($sformatf("%s[%0d]", tag, i), plan[i].rdy, plan[i].exp);
        plan.delete();
    endtask

    // Asynchronous reset asserted mid-cycle, released just after an edge
    task automatic do_reset(input string tag);
        obs_t r = '0;
        r.rw_type = cur_f3;
        #2 rst_n = 1'b0;
        #1 chk({tag, "_rst_async"}, act_obs(), r);
        @(negedge clk);
        chk({tag, "_rst_hold"}, act_obs(), r);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ill_s  = 1'b0;
        berr_s = 1'b0;
    endtask

    task automatic do_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic bc, input int dF, input int dM);
        bit trapped;
        bus.opcode  = op;
        bus.func3   = f3;
        bus.br_cond = bc;
        cur_f3      = f3;
        trapped     = build(op, f3, bc, dF, dM);
        run_plan(tag, plan.size());
        if (trapped) do_reset(tag);
    endtask

    initial begin
        obs_t r;
        bit   t;
        rst_n         = 1'b0;
        ill_s         = 1'b0;
        berr_s        = 1'b0;
        bus.opcode    = 7'b0110011;
        bus.func3     = 3'b101;
        cur_f3        = 3'b101;
        bus.br_cond   = 1'b0;
        bus.mem_ready = 1'b1;
        r             = '0;
        r.rw_type     = 3'b101;
        #1 chk("reset", act_obs(), r);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_instr("add",        7'b0110011, 3'b000, 1'b0, 0, 0);
        do_instr("lw_wait3",   7'b0000011, 3'b010, 1'b0, 0, 3);
        do_instr("beq_taken",  7'b1100011, 3'b000, 1'b1, 0, 0);
        do_instr("beq_not",    7'b1100011, 3'b000, 1'b0, 0, 0);
        do_instr("jal",        7'b1101111, 3'b000, 1'b0, 1, 0);
        do_instr("jalr",       7'b1100111, 3'b000, 1'b0, 0, 0);
        do_instr("fetch_to",   7'b0110011, 3'b000, 1'b0, 9, 0);
        do_instr("fetch_edge", 7'b0110011, 3'b000, 1'b0, 3, 0);
        do_instr("illegal",    7'b0000000, 3'b000, 1'b0, 0, 0);
        do_instr("sw",         7'b0100011, 3'b010, 1'b0, 0, 2);
        do_instr("mem_to",     7'b0000011, 3'b001, 1'b0, 0, 7);

        // Store abandoned by reset while waiting in MEM
        bus.opcode  = 7'b0100011;
        bus.func3   = 3'b010;
        bus.br_cond = 1'b0;
        cur_f3      = 3'b010;
        t = build(7'b0100011, 3'b010, 1'b0, 0, 3);
        if (t) $display("note: unexpected trap in sw plan");
        run_plan("sw_mid", 5);
        do_reset("sw_mid");
        do_instr("after_rst",  7'b0010011, 3'b011, 1'b0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            logic [6:0] op;
            int         dF, dM;
            if ($urandom_range(0, 10) < 10) op = ops[$urandom_range(0, 8)];
            else                            op = 7'($urandom);
            dF = ($urandom_range(0, 15) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, TMO - 1);
            dM = ($urandom_range(0, 15) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, TMO - 1);
            do_instr($sformatf("rand%0d", n), op, 3'($urandom), 1'($urandom), dF, dM);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
